// File: rtl/store_commit_buffer_pkg.sv
// Shared sizing, entry/drain state encodings and the per-entry payload for the store commit buffer.
package store_commit_buffer_pkg;
  localparam int SB_ENTRIES = 16;
  localparam int PTR_W      = 4;
  localparam int ROB_ID_W   = 6;
  localparam int NUM_LANES  = 4;

  typedef enum logic [1:0] {ST_FREE, ST_ALLOC, ST_EXEC, ST_CMT} sb_state_e;
  typedef enum logic       {DR_IDLE, DR_REQ} drain_state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} sb_size_e;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [31:0]         addr;
    logic [31:0]         data;
    logic [1:0]          size;
  } sb_entry_t;
endpackage

// File: rtl/store_commit_buffer_if.sv
// Drain-side write request bus from the store buffer to the data cache.
interface store_commit_buffer_if;
  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_data_o;
  logic [3:0]  mem_req_be_o;
  logic        mem_req_ready_i;

  modport master (output mem_req_valid_o, mem_req_addr_o, mem_req_data_o, mem_req_be_o,
                  input  mem_req_ready_i);
  modport slave  (input  mem_req_valid_o, mem_req_addr_o, mem_req_data_o, mem_req_be_o,
                  output mem_req_ready_i);
endinterface

// File: rtl/store_commit_buffer_sb_lane_align.sv
// Turns size + low address bits + LSB-aligned data into byte enables and lane-replicated data.
module sb_lane_align
  import store_commit_buffer_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);
  always_comb begin
    be        = 4'h0;
    lane_data = data;
    case (sb_size_e'(size))
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {NUM_LANES{data[7:0]}};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        lane_data = {2{data[15:0]}};
      end
      SZ_WORD: be = 4'hF;
      default: be = 4'h0;
    endcase
  end
endmodule

// File: rtl/store_commit_buffer.sv
// Store buffer: holds speculative stores, commits in ROB order, drains committed stores in order.
// Define STORE_FWD_EN to add the youngest-match store-to-load forwarding port.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid_i,
  input  logic [ROB_ID_W-1:0] alloc_rob_id_i,
  output logic                alloc_ready_o,
  output logic [PTR_W-1:0]    alloc_sb_id_o,
  input  logic                exec_valid_i,
  input  logic [PTR_W-1:0]    exec_sb_id_i,
  input  logic [31:0]         exec_addr_i,
  input  logic [31:0]         exec_data_i,
  input  logic [1:0]          exec_size_i,
  input  logic                commit_valid_i,
  input  logic [ROB_ID_W-1:0] commit_rob_id_i,
  input  logic                flush_i,
  store_commit_buffer_if.master mem,
  output logic                commit_err_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [PTR_W:0]      count_o
`ifdef STORE_FWD_EN
  ,
  input  logic [31:0]         fwd_addr_i,
  output logic                fwd_hit_o,
  output logic [31:0]         fwd_data_o,
  output logic [3:0]          fwd_be_o
`endif
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(SB_ENTRIES);

  sb_state_e        st_q [SB_ENTRIES];
  sb_state_e        st_d [SB_ENTRIES];
  sb_entry_t        ent_q [SB_ENTRIES];
  logic [PTR_W-1:0] head_q, cmt_q, tail_q, cmt_d;
  logic [PTR_W:0]   count_q, ncmt_q, ncmt_d;
  drain_state_e     dr_q, dr_d;
  logic             alloc_fire, exec_fire, commit_ok, head_cmt, dr_load, drain_fire;
  logic             commit_err_q;
  logic [31:0]      req_addr_q, req_data_q, head_data;
  logic [3:0]       req_be_q, head_be;

  assign full_o        = (count_q == FULL_CNT);
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign alloc_ready_o = !full_o;
  assign alloc_sb_id_o = tail_q;
  assign commit_err_o  = commit_err_q;

  assign alloc_fire = alloc_valid_i && alloc_ready_o && !flush_i;
  assign exec_fire  = exec_valid_i && !flush_i && (st_q[exec_sb_id_i] == ST_ALLOC);
  assign commit_ok  = commit_valid_i && (st_q[cmt_q] == ST_EXEC) &&
                      (ent_q[cmt_q].rob_id == commit_rob_id_i);
  assign cmt_d      = cmt_q + PTR_W'(commit_ok);
  // Committed-entry count is tracked separately: cmt_ptr - head aliases to 0 when all 16 are committed.
  assign ncmt_d     = ncmt_q + (PTR_W+1)'(commit_ok) - (PTR_W+1)'(drain_fire);
  // Bypass the commit pulse so the request can appear the cycle right after commit.
  assign head_cmt   = (st_q[head_q] == ST_CMT) || (commit_ok && (cmt_q == head_q));

  // Commit is applied before flush, so a store committed in the flush cycle survives.
  always_comb begin
    for (int i = 0; i < SB_ENTRIES; i++) st_d[i] = st_q[i];
    if (alloc_fire) st_d[tail_q]       = ST_ALLOC;
    if (exec_fire)  st_d[exec_sb_id_i] = ST_EXEC;
    if (commit_ok)  st_d[cmt_q]        = ST_CMT;
    if (drain_fire) st_d[head_q]       = ST_FREE;
    if (flush_i)
      for (int i = 0; i < SB_ENTRIES; i++)
        if (st_d[i] == ST_ALLOC || st_d[i] == ST_EXEC) st_d[i] = ST_FREE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_ENTRIES; i++) begin
        st_q[i]  <= ST_FREE;
        ent_q[i] <= '0;
      end
      head_q       <= '0;
      cmt_q        <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ncmt_q       <= '0;
      commit_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < SB_ENTRIES; i++) st_q[i] <= st_d[i];
      if (alloc_fire) ent_q[tail_q].rob_id <= alloc_rob_id_i;
      if (exec_fire) begin
        ent_q[exec_sb_id_i].addr <= exec_addr_i;
        ent_q[exec_sb_id_i].data <= exec_data_i;
        ent_q[exec_sb_id_i].size <= exec_size_i;
      end
      cmt_q  <= cmt_d;
      ncmt_q <= ncmt_d;
      if (drain_fire) head_q <= head_q + 1'b1;
      if (flush_i) begin
        tail_q  <= cmt_d;
        count_q <= ncmt_d;
      end else begin
        if (alloc_fire) tail_q <= tail_q + 1'b1;
        count_q <= count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(drain_fire);
      end
      commit_err_q <= commit_valid_i && !commit_ok;
    end
  end

  sb_lane_align u_drain_align (
    .size      (ent_q[head_q].size),
    .addr_lo   (ent_q[head_q].addr[1:0]),
    .data      (ent_q[head_q].data),
    .be        (head_be),
    .lane_data (head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dr_q <= DR_IDLE;
    else        dr_q <= dr_d;
  end

  always_comb begin
    dr_d       = dr_q;
    dr_load    = 1'b0;
    drain_fire = 1'b0;
    case (dr_q)
      DR_IDLE: if (head_cmt) begin
        dr_d    = DR_REQ;
        dr_load = 1'b1;
      end
      DR_REQ: if (mem.mem_req_ready_i) begin
        dr_d       = DR_IDLE;
        drain_fire = 1'b1;
      end
      default: dr_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q <= '0;
      req_data_q <= '0;
      req_be_q   <= '0;
    end else if (dr_load) begin
      req_addr_q <= {ent_q[head_q].addr[31:2], 2'b00};
      req_data_q <= head_data;
      req_be_q   <= head_be;
    end
  end

  assign mem.mem_req_valid_o = (dr_q == DR_REQ);
  assign mem.mem_req_addr_o  = req_addr_q;
  assign mem.mem_req_data_o  = req_data_q;
  assign mem.mem_req_be_o    = req_be_q;

`ifdef STORE_FWD_EN
  logic [3:0]       e_be   [SB_ENTRIES];
  logic [31:0]      e_data [SB_ENTRIES];
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_fwd_lo;
  assign unused_fwd_lo = ^fwd_addr_i[1:0];

  for (genvar g = 0; g < SB_ENTRIES; g++) begin : g_fwd
    sb_lane_align u_align (
      .size      (ent_q[g].size),
      .addr_lo   (ent_q[g].addr[1:0]),
      .data      (ent_q[g].data),
      .be        (e_be[g]),
      .lane_data (e_data[g])
    );
  end

  // Walk oldest to youngest; later hits overwrite so the youngest match wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_be_o   = '0;
    fwd_idx    = head_q;
    for (int k = 0; k < SB_ENTRIES; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((st_q[fwd_idx] == ST_EXEC || st_q[fwd_idx] == ST_CMT) &&
          ent_q[fwd_idx].addr[31:2] == fwd_addr_i[31:2]) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = e_data[fwd_idx];
        fwd_be_o   = e_be[fwd_idx];
      end
    end
  end
`endif
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
Holds stores from dispatch through execute and ROB commit, then drains committed stores to the data cache in program order. Sits directly downstream of the reorder buffer and consumes its store-commit pulse (valid + ROB ID). Stores are speculative until committed; flush discards only uncommitted entries. Committed entries always drain.

Parameters:
SB_ENTRIES, 16, number of buffer entries (power of two)
PTR_W, 4, log2(SB_ENTRIES)
ROB_ID_W, 6, ROB ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_valid_i  in  1  dispatch allocates a store entry
alloc_rob_id_i  in  ROB_ID_W  ROB ID of allocated store
alloc_ready_o  out  1  entry available (!full_o)
alloc_sb_id_o  out  PTR_W  entry index being allocated (= tail)
exec_valid_i  in  1  LSU delivers address/data
exec_sb_id_i  in  PTR_W  target entry
exec_addr_i  in  32  byte address
exec_data_i  in  32  store data, LSB-aligned
exec_size_i  in  2  0=byte 1=half 2=word 3=reserved
commit_valid_i  in  1  ROB store commit pulse
commit_rob_id_i  in  ROB_ID_W  committed store's ROB ID
flush_i  in  1  pipeline flush from ROB
mem_req_valid_o  out  1  drain write request
mem_req_addr_o  out  32  word-aligned address
mem_req_data_o  out  32  lane-positioned data
mem_req_be_o  out  4  byte enables
mem_req_ready_i  in  1  cache accepts request
commit_err_o  out  1  one-cycle pulse on illegal commit
full_o  out  1  count == SB_ENTRIES
empty_o  out  1  count == 0
count_o  out  PTR_W+1  occupied entries

Behaviour:
- Reset: all entries FREE; head, cmt_ptr, tail = 0; count 0; mem_req_valid_o 0, addr/data/be 0; commit_err_o 0; empty_o 1; full_o 0.
- Per-entry state: FREE -> ALLOC on allocate -> EXEC on exec write -> COMMITTED on commit -> FREE on drain handshake.
- Three pointers: head (oldest, drain), cmt_ptr (oldest uncommitted), tail (next free).
- Allocate when alloc_valid_i && alloc_ready_o: entry[tail] <- ALLOC, stores rob_id; tail++ with wrap at SB_ENTRIES.
- Exec write: accepted only if entry is ALLOC; otherwise ignored. Latches addr, data, size.
- Commit: legal only if entry[cmt_ptr] is EXEC and its rob_id == commit_rob_id_i. Then it goes to COMMITTED and cmt_ptr++. Otherwise no state change, and commit_err_o pulses the next cycle.
- Byte enables/data:
  - size0: be = 4'b0001 << addr[1:0]; data byte replicated to all lanes.
  - size1: be = 4'b0011 << {addr[1],1'b0}; data half replicated.
  - size2: be = 4'hF.
  - size3: be = 0.
  - Misaligned stores never commit (the LSU excepts), so no special handling.
  - mem_req_addr_o = {addr[31:2],2'b00}.
- Drain FSM IDLE/REQ:
  - IDLE: if entry[head] is COMMITTED, register the request outputs and go to REQ. The request is visible the cycle after the commit pulse at the earliest.
  - REQ: hold mem_req_valid_o and its outputs stable until mem_req_ready_i. On the handshake, free entry[head], head++, and return to IDLE. Back-to-back committed entries issue at most every 2 cycles.
- Flush: all ALLOC/EXEC entries -> FREE; tail <- cmt_ptr; count <- committed entries still held (cmt_ptr - head). An in-flight REQ continues.
- Simultaneous events:
  - Commit + flush in the same cycle: commit applies first, so the committed entry survives.
  - Alloc + flush: alloc dropped.
  - Exec + flush to the same entry: flush wins.
  - Drain handshake + alloc: count unchanged.
- count_o is registered. alloc_ready_o derives from registered count, so a full buffer does not accept alloc even when a drain happens that cycle.
- Wrap: pointers are PTR_W bits wide, with natural wrap. Full/empty are decided by count, not by pointer compare.
- Reset mid-REQ: the request drops immediately (async); the cache side must tolerate this.

Optional Feature:
STORE_FWD_EN: adds ports fwd_addr_i[31:0], fwd_hit_o, fwd_data_o[31:0], fwd_be_o[3:0].
- Combinational search from youngest to oldest over EXEC/COMMITTED entries for a matching word address.
- Returns the youngest match's positioned data and be; fwd_hit_o = 1 on a match.
- Without the macro: ports absent and no search logic.

Decomposition:
- Shared package/include: SB_ENTRIES, entry-state encodings (FREE/ALLOC/EXEC/COMMITTED), drain FSM encodings, size encodings.
- One natural sub-module: sb_lane_align (size + addr[1:0] + data -> be + positioned data), shared by drain and forwarding.

Test Plan:
1. Alloc rob 5, exec addr 0x1003 size0 data 0xAB, commit rob 5, ready=1 -> one cycle later mem_req addr 0x1000 be 4'b1000 data 0xABABABAB; then empty_o=1.
2. Alloc 16 stores -> full_o=1, alloc_ready_o=0; a 17th alloc is ignored; drain one -> alloc_ready_o=1 next cycle.
3. Alloc 3 stores, exec all, commit first, flush -> count_o=1; only the first drains; alloc_sb_id_o equals the old cmt_ptr.
4. Commit rob 7 while cmt_ptr entry holds rob 6 -> commit_err_o pulses once, nothing drains.
5. Hold mem_req_ready_i=0 for 5 cycles with 2 committed entries -> outputs stable; first released on ready, second issued 2 cycles later.
6. Fill past wrap (tail 15 -> 0) with interleaved drains -> order preserved, addresses in program order.
